// File: rtl/simon_pkg.sv
// Shared Simon definitions: segment codes, the code<->LED mapping used by both player and input checker, player states.
package simon_pkg;

    localparam int SEQ_MAX = 33;
    localparam int IDX_W   = 6;
    localparam int LED_W   = 4;

    typedef logic [1:0] seg_code_t;

    typedef enum logic [1:0] {
        IDLE,
        ON,
        OFF,
        DONE
    } player_state_t;

    // One-hot LED n lights for code n; onehot_to_code is its exact inverse.
    function automatic logic [LED_W-1:0] code_to_onehot(input seg_code_t code);
        return LED_W'(1) << code;
    endfunction

    function automatic seg_code_t onehot_to_code(input logic [LED_W-1:0] led);
        seg_code_t code;
        case (led)
            4'b0010: code = 2'd1;
            4'b0100: code = 2'd2;
            4'b1000: code = 2'd3;
            default: code = 2'd0;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/sequence_player_if.sv
// Game-FSM <-> sequence player bundle; the player sits on the slave modport.
interface sequence_player_if;

    logic                                           start;
    logic                                           abort;
    logic [simon_pkg::IDX_W-1:0]                    round_len;
    simon_pkg::seg_code_t [simon_pkg::SEQ_MAX-1:0]  segment;
    logic [simon_pkg::LED_W-1:0]                    led;
    logic                                           busy;
    logic [simon_pkg::IDX_W-1:0]                    play_index;
    logic                                           done;

    modport master (
        output start, abort, round_len, segment,
        input  led, busy, play_index, done
    );

    modport slave (
        input  start, abort, round_len, segment,
        output led, busy, play_index, done
    );

endinterface

// File: rtl/sequence_player_phase_timer.sv
// Loadable down-counter for the ON/OFF phases; load wins over decrement, count parks at zero.
// Latency: expired reflects the registered count, no backpressure.
module phase_timer #(
    parameter int CNT_W = 25
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_expired
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_expired = (r_count == '0);

endmodule

// File: rtl/sequence_player.sv
// Plays a snapshotted Simon sequence as one-hot LED flashes with dark gaps; done pulses after the last gap.
// Latency: LED valid one cycle after start; no backpressure, abort stops playback on the next edge.
module sequence_player
    import simon_pkg::*;
#(
    parameter int ON_CYCLES  = 25_000_000,
    parameter int OFF_CYCLES = 12_500_000,
    parameter int CNT_W      = 25
) (
    input  logic              clk,
    input  logic              rst_n,
    sequence_player_if.slave  sp
);

    localparam logic [CNT_W-1:0] ON_LOAD  = CNT_W'(ON_CYCLES - 1);
    localparam logic [CNT_W-1:0] OFF_LOAD = CNT_W'(OFF_CYCLES - 1);

    player_state_t                r_state;
    logic [LED_W-1:0]             r_led;
    logic                         r_busy;
    logic                         r_done;
    logic [IDX_W-1:0]             r_play_index;
    logic [IDX_W-1:0]             r_len;
    seg_code_t [SEQ_MAX-1:0]      r_snap;

    logic [IDX_W-1:0]             w_len_clamped;
    logic [IDX_W-1:0]             w_next_idx;
    logic                         w_last;
    logic                         w_accept;
    logic                         w_tmr_load;
    logic [CNT_W-1:0]             w_tmr_val;
    logic                         w_tmr_dec;
    logic                         w_tmr_expired;

    assign w_len_clamped = (sp.round_len > IDX_W'(SEQ_MAX)) ? IDX_W'(SEQ_MAX) : sp.round_len;
    assign w_next_idx    = r_play_index + 1'b1;
    assign w_last        = (r_play_index == (r_len - 1'b1));
    assign w_accept      = (r_state == IDLE) && sp.start && !sp.abort;
    assign w_tmr_dec     = (r_state == ON) || (r_state == OFF);

    // Reload points mirror the FSM transitions below; abort parks the timer at zero.
    always_comb begin
        w_tmr_load = 1'b0;
        w_tmr_val  = '0;
        if (r_state == IDLE) begin
            if (w_accept && (w_len_clamped != '0)) begin
                w_tmr_load = 1'b1;
                w_tmr_val  = ON_LOAD;
            end
        end else if (sp.abort) begin
            w_tmr_load = 1'b1;
        end else if ((r_state == ON) && w_tmr_expired) begin
            w_tmr_load = 1'b1;
            w_tmr_val  = OFF_LOAD;
        end else if ((r_state == OFF) && w_tmr_expired && !w_last) begin
            w_tmr_load = 1'b1;
            w_tmr_val  = ON_LOAD;
        end
    end

    phase_timer #(
        .CNT_W (CNT_W)
    ) u_phase_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_val),
        .i_dec      (w_tmr_dec),
        .o_expired  (w_tmr_expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_led        <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_play_index <= '0;
            r_len        <= '0;
            r_snap       <= '0;
        end else if ((r_state != IDLE) && sp.abort) begin
            r_state <= IDLE;
            r_led   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (w_accept) begin
                        r_snap       <= sp.segment;
                        r_len        <= w_len_clamped;
                        r_play_index <= '0;
                        if (w_len_clamped == '0) begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= ON;
                            r_led   <= code_to_onehot(sp.segment[0]);
                            r_busy  <= 1'b1;
                        end
                    end
                end
                ON: begin
                    if (w_tmr_expired) begin
                        r_state <= OFF;
                        r_led   <= '0;
                    end
                end
                OFF: begin
                    if (w_tmr_expired) begin
                        if (w_last) begin
                            r_state <= DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_state      <= ON;
                            r_play_index <= w_next_idx;
                            r_led        <= code_to_onehot(r_snap[w_next_idx]);
                        end
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_done  <= 1'b0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign sp.led        = r_led;
    assign sp.busy       = r_busy;
    assign sp.done       = r_done;
    assign sp.play_index = r_play_index;

endmodule

// File: tb/tb_sequence_player.sv
// Bench for sequence_player with short phases; expected traces come from a per-element timeline model.
module tb_sequence_player;

    localparam int ON_C  = 3;
    localparam int OFF_C = 2;
    localparam int CW    = 4;
    localparam int SMAX  = 33;

    typedef struct packed {
        logic [3:0] led;
        logic       busy;
        logic [5:0] idx;
        logic       done;
    } obs_t;

    typedef struct {
        int         rlen;
        logic [1:0] code0;
        logic [3:0] first_led;
        int         done_at;
        int         peak;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk  = 0;
    int   n_pass = 0;

    logic [3:0] led_of [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};

    always #5 clk = ~clk;

    sequence_player_if sp();

    sequence_player #(
        .ON_CYCLES  (ON_C),
        .OFF_CYCLES (OFF_C),
        .CNT_W      (CW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sp    (sp)
    );

    function automatic obs_t observe();
        obs_t o;
        o.led  = sp.led;
        o.busy = sp.busy;
        o.idx  = sp.play_index;
        o.done = sp.done;
        return o;
    endfunction

    function automatic logic [65:0] rand66();
        logic [95:0] t;
        t = {$urandom, $urandom, $urandom};
        return t[65:0];
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h) at %0t", nm, got, got, exp, exp, $time);
    endtask

    task automatic chk_obs(input string nm, input obs_t got, input obs_t exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got led=%b busy=%b idx=%0d done=%b want led=%b busy=%b idx=%0d done=%b at %0t",
                      nm, got.led, got.busy, got.idx, got.done, exp.led, exp.busy, exp.idx, exp.done, $time);
    endtask

    // Timeline: each element is ON_C lit cycles then OFF_C dark cycles, then a done cycle and an idle cycle.
    task automatic build_model(input int rlen, input logic [65:0] seg, output obs_t q[$]);
        int n;
        int last;
        q = {};
        n = (rlen > SMAX) ? SMAX : rlen;
        for (int i = 0; i < n; i++) begin
            for (int c = 0; c < ON_C; c++)  q.push_back('{led_of[seg[2*i +: 2]], 1'b1, 6'(i), 1'b0});
            for (int c = 0; c < OFF_C; c++) q.push_back('{4'b0000, 1'b1, 6'(i), 1'b0});
        end
        last = (n == 0) ? 0 : n - 1;
        q.push_back('{4'b0000, 1'b0, 6'(last), 1'b1});
        q.push_back('{4'b0000, 1'b0, 6'(last), 1'b0});
    endtask

    // Called at a negedge; leaves the bench at the negedge of the trailing idle cycle.
    task automatic play(input string nm, input int rlen, input logic [65:0] seg, input bit noise);
        obs_t q[$];
        build_model(rlen, seg, q);
        sp.round_len = 6'(rlen);
        sp.segment   = seg;
        sp.start     = 1'b1;
        for (int k = 0; k < q.size(); k++) begin
            @(negedge clk);
            sp.start = 1'b0;
            chk_obs(nm, observe(), q[k]);
            if (noise && (k < q.size() - 1)) begin
                sp.start     = (k == q.size() - 2) ? 1'b1 : 1'($urandom_range(0, 1));
                sp.segment   = rand66();
                sp.round_len = 6'($urandom);
            end
        end
        sp.start = 1'b0;
    endtask

    initial begin
        vec_t       vecs[$];
        logic [65:0] seg;
        obs_t       o;
        logic [3:0] first_led;
        int         done_at;
        int         peak;
        bit         lit;

        sp.start     = 1'b0;
        sp.abort     = 1'b0;
        sp.round_len = '0;
        sp.segment   = '0;

        #1;
        chk_obs("reset_state", observe(), '{4'b0000, 1'b0, 6'd0, 1'b0});
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Mapping sequence: elements 00,01,10,11.
        play("mapping", 4, {58'd0, 8'b11_10_01_00}, 1'b0);

        vecs.push_back('{4,  2'd0, 4'b0001, 20,  3});
        vecs.push_back('{1,  2'd3, 4'b1000, 5,   0});
        vecs.push_back('{0,  2'd2, 4'b0000, 0,   0});
        vecs.push_back('{40, 2'd1, 4'b0010, 165, 32});
        vecs.push_back('{33, 2'd2, 4'b0100, 165, 32});
        vecs.push_back('{2,  2'd3, 4'b1000, 10,  1});
        vecs.push_back('{63, 2'd0, 4'b0001, 165, 32});
        foreach (vecs[v]) begin
            seg = rand66();
            seg[1:0] = vecs[v].code0;
            sp.round_len = 6'(vecs[v].rlen);
            sp.segment   = seg;
            sp.start     = 1'b1;
            done_at = -1; peak = 0; lit = 1'b0; first_led = 4'hx;
            for (int k = 0; k < 300 && done_at < 0; k++) begin
                @(negedge clk);
                sp.start = 1'b0;
                o = observe();
                if (k == 0) first_led = o.led;
                if (o.led != 4'b0000 || o.busy) lit = 1'b1;
                if (int'(o.idx) > peak) peak = int'(o.idx);
                if (o.done) done_at = k;
            end
            chk("vec_first_led", 32'(first_led), 32'(vecs[v].first_led));
            chk("vec_done_at",   32'(done_at),   32'(vecs[v].done_at));
            chk("vec_peak_idx",  32'(peak),      32'(vecs[v].peak));
            chk("vec_lit",       32'(lit),       32'(vecs[v].rlen != 0));
            @(negedge clk);
        end

        // start and abort together in IDLE: stays idle.
        sp.round_len = 6'd3;
        sp.start = 1'b1;
        sp.abort = 1'b1;
        @(negedge clk);
        sp.start = 1'b0;
        sp.abort = 1'b0;
        chk("start_abort_idle_busy", 32'(sp.busy), 32'd0);
        @(negedge clk);
        chk("start_abort_idle_done", 32'(sp.done), 32'd0);

        // Snapshot: altering segment[1] during element 0 must not change element 1.
        seg = {60'd0, 6'b00_10_11};
        sp.round_len = 6'd2;
        sp.segment   = seg;
        sp.start     = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            sp.start = 1'b0;
            if (k == 1) sp.segment[1] = 2'b01;
            if (k == 5) chk("snapshot_led", 32'(sp.led), 32'(4'b0100));
        end

        // Abort during the ON phase of element 2 of 5.
        seg = rand66();
        sp.round_len = 6'd5;
        sp.segment   = seg;
        sp.start     = 1'b1;
        for (int k = 0; k <= 10; k++) begin
            @(negedge clk);
            sp.start = 1'b0;
        end
        chk("abort_pre_led", 32'(sp.led), 32'(led_of[seg[5:4]]));
        sp.abort = 1'b1;
        @(negedge clk);
        sp.abort = 1'b0;
        chk_obs("abort_next", observe(), '{4'b0000, 1'b0, 6'd2, 1'b0});
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("abort_no_done", 32'({sp.done, sp.busy}), 32'd0);
        end
        play("after_abort", 5, rand66(), 1'b0);

        // Asynchronous reset during the OFF phase of element 0.
        sp.round_len = 6'd3;
        sp.segment   = rand66();
        sp.start     = 1'b1;
        for (int k = 0; k <= 3; k++) begin
            @(negedge clk);
            sp.start = 1'b0;
        end
        chk("pre_reset_off", 32'({sp.busy, sp.led}), 32'(5'b10000));
        #2 rst_n = 1'b0;
        #1;
        chk_obs("async_reset", observe(), '{4'b0000, 1'b0, 6'd0, 1'b0});
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk_obs("post_reset_idle", observe(), '{4'b0000, 1'b0, 6'd0, 1'b0});
        play("after_reset", 3, rand66(), 1'b0);

        // Random lengths, with spurious start pulses (including in DONE) and input churn mid-playback.
        for (int r = 0; r < 10; r++) begin
            play("random", int'($urandom_range(0, 40)), rand66(), 1'b1);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
